// File: rtl/phase_gen_pkg.sv
// Shared types and limits for the phase generator: sequencer state encoding
// and the legal range of phase strobes per instruction cycle.
package phase_gen_pkg;

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        SINGLE = 2'd3
    } state_e;

    localparam int MIN_PHASES = 2;
    localparam int MAX_PHASES = 16;

endpackage

// File: rtl/phase_gen_onehot_dec.sv
// Combinational index-to-one-hot decoder. Indices at or beyond NUM_PHASES
// decode to all zero, so a non-power-of-two phase count never aliases.
module onehot_dec #(
    parameter int NUM_PHASES = 4,
    parameter int IDX_W      = $clog2(NUM_PHASES)
) (
    input  logic [IDX_W-1:0]      idx_i,
    output logic [NUM_PHASES-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            onehot_o[i] = (idx_i == IDX_W'(i));
        end
    end

endmodule

// File: rtl/phase_gen.sv
// Instruction-cycle phase sequencer: issues one-hot phase strobes under
// RUN / STEP / HOLD control. Optional cycle counter: PHASE_GEN_CYCLE_CNT_EN.
module phase_gen
    import phase_gen_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int IDX_W      = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run_i,
    input  logic                  step_i,
    input  logic                  hold_i,
    output logic [NUM_PHASES-1:0] phase_o,
    output logic [IDX_W-1:0]      phase_idx_o,
    output logic                  cycle_done_o,
    output logic                  busy_o
`ifdef PHASE_GEN_CYCLE_CNT_EN
    ,
    output logic [31:0]           cycle_count_o
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

    if (NUM_PHASES < MIN_PHASES || NUM_PHASES > MAX_PHASES) begin : g_bad_num_phases
        $error("phase_gen: NUM_PHASES out of legal range");
    end

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        count_q, count_d;
    logic [NUM_PHASES-1:0]   phase_q, phase_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic [NUM_PHASES-1:0]   phase_dec;
    logic                    advance;
    logic                    at_last;

    assign at_last = (count_q == LAST_IDX);

    onehot_dec #(
        .NUM_PHASES (NUM_PHASES),
        .IDX_W      (IDX_W)
    ) u_dec (
        .idx_i    (count_q),
        .onehot_o (phase_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD freezes every busy state; in STOP it only blocks STEP, so a RUN
    // request is accepted and simply waits for HOLD to drop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STOP: begin
                if (run_i) begin
                    state_d = RUN;
                end else if (step_i && !hold_i) begin
                    state_d = SINGLE;
                end
            end
            RUN: begin
                if (!hold_i && !run_i) begin
                    state_d = (count_q == '0 || at_last) ? STOP : DRAIN;
                end
            end
            DRAIN: begin
                if (!hold_i) begin
                    if (run_i) begin
                        state_d = RUN;
                    end else if (at_last) begin
                        state_d = STOP;
                    end
                end
            end
            SINGLE: begin
                if (!hold_i && at_last) begin
                    state_d = STOP;
                end
            end
            default: state_d = STOP;
        endcase
    end

    // A RUN drop at a cycle boundary stops cleanly without issuing phase 0.
    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            RUN:           advance = !hold_i && (run_i || count_q != '0);
            DRAIN, SINGLE: advance = !hold_i;
            default:       advance = 1'b0;
        endcase

        count_d = count_q;
        if (state_q == STOP) begin
            count_d = '0;
        end else if (advance) begin
            count_d = at_last ? '0 : count_q + IDX_W'(1);
        end

        phase_d = advance ? phase_dec : '0;
        idx_d   = advance ? count_q : idx_q;
        done_d  = advance && at_last;
        busy_d  = (state_d != STOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign phase_o      = phase_q;
    assign phase_idx_o  = idx_q;
    assign cycle_done_o = done_q;
    assign busy_o       = busy_q;

`ifdef PHASE_GEN_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else if (done_d) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_count_o = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen: a 4-phase and a 5-phase instance share
// clock, reset and control inputs; each scenario checks the relevant instance.
module tb_phase_gen;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       step;
    logic       hold;

    logic [3:0] p4;
    logic [1:0] idx4;
    logic       done4;
    logic       busy4;
    logic [4:0] p5;
    logic [2:0] idx5;
    logic       done5;
    logic       busy5;
`ifdef PHASE_GEN_CYCLE_CNT_EN
    logic [31:0] cc4;
    logic [31:0] cc5;
`endif

    int vectors;
    int miscompares;

    phase_gen #(.NUM_PHASES(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run),
        .step_i       (step),
        .hold_i       (hold),
        .phase_o      (p4),
        .phase_idx_o  (idx4),
        .cycle_done_o (done4),
        .busy_o       (busy4)
`ifdef PHASE_GEN_CYCLE_CNT_EN
        ,
        .cycle_count_o (cc4)
`endif
    );

    phase_gen #(.NUM_PHASES(5)) dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run),
        .step_i       (step),
        .hold_i       (hold),
        .phase_o      (p5),
        .phase_idx_o  (idx5),
        .cycle_done_o (done5),
        .busy_o       (busy5)
`ifdef PHASE_GEN_CYCLE_CNT_EN
        ,
        .cycle_count_o (cc5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; run = 1'b1; step = 1'b0; hold = 1'b0;
        #1;
        vectors++;
        if ({p4, idx4, done4, busy4} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset4: got %b %b %b %b want all zero", p4, idx4, done4, busy4);
        end
        vectors++;
        if ({p5, idx5, done5, busy5} !== 10'h000) begin
            miscompares++;
            $display("[TB] FAIL reset5: got %b %b %b %b want all zero", p5, idx5, done5, busy5);
        end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (p4 !== 4'b0000 || busy4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL release_edge: phase %b busy %b want 0000 1", p4, busy4);
        end
    endtask

    task automatic test_run4;
        run = 1'b1;
        do_reset();
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (p4 !== 4'(1 << (i % 4)) || idx4 !== 2'(i % 4) || done4 !== (i % 4 == 3)) begin
                miscompares++;
                $display("[TB] FAIL run4[%0d]: phase %b idx %0d done %b want %b %0d %b",
                         i, p4, idx4, done4, 4'(1 << (i % 4)), i % 4, (i % 4 == 3));
            end
        end
    endtask

    task automatic test_drain5;
        logic [4:0] exp_p [3] = '{5'b00100, 5'b01000, 5'b10000};
        run = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        vectors++;
        if (p5 !== 5'b00010) begin
            miscompares++;
            $display("[TB] FAIL drain5_pre: phase %b want 00010", p5);
        end
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (p5 !== exp_p[i] || done5 !== (i == 2)) begin
                miscompares++;
                $display("[TB] FAIL drain5[%0d]: phase %b done %b want %b %b",
                         i, p5, done5, exp_p[i], (i == 2));
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (p5 !== 5'b00000 || busy5 !== 1'b0 || done5 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL drain5_stop[%0d]: phase %b busy %b done %b want 00000 0 0",
                         i, p5, busy5, done5);
            end
        end
    endtask

    task automatic test_step;
        run = 1'b0;
        do_reset();
        tick();
        vectors++;
        if (p4 !== 4'b0000 || busy4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL step_idle: phase %b busy %b want 0000 0", p4, busy4);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        vectors++;
        if (p4 !== 4'b0000 || busy4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL step_enter: phase %b busy %b want 0000 1", p4, busy4);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) step = 1'b1;
            tick();
            step = 1'b0;
            vectors++;
            if (p4 !== 4'(1 << i) || done4 !== (i == 3)) begin
                miscompares++;
                $display("[TB] FAIL step[%0d]: phase %b done %b want %b %b", i, p4, done4, 4'(1 << i), (i == 3));
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (p4 !== 4'b0000 || busy4 !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL step_stop[%0d]: phase %b busy %b want 0000 0", i, p4, busy4);
            end
        end
    endtask

    task automatic test_hold;
        run = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        vectors++;
        if (p4 !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL hold_pre: phase %b want 0100", p4);
        end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (p4 !== 4'b0000 || done4 !== 1'b0 || busy4 !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL hold[%0d]: phase %b done %b busy %b want 0000 0 1", i, p4, done4, busy4);
            end
        end
        hold = 1'b0;
        tick();
        vectors++;
        if (p4 !== 4'b1000 || done4 !== 1'b1 || idx4 !== 2'd3) begin
            miscompares++;
            $display("[TB] FAIL hold_resume: phase %b done %b idx %0d want 1000 1 3", p4, done4, idx4);
        end
        tick();
        vectors++;
        if (p4 !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL hold_wrap: phase %b want 0001", p4);
        end
    endtask

    task automatic test_hold_stop;
        run = 1'b0;
        do_reset();
        hold = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        vectors++;
        if (busy4 !== 1'b0 || p4 !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL hold_stop_step: busy %b phase %b want 0 0000", busy4, p4);
        end
        run = 1'b1;
        tick();
        vectors++;
        if (busy4 !== 1'b1 || p4 !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL hold_stop_run: busy %b phase %b want 1 0000", busy4, p4);
        end
        tick();
        vectors++;
        if (p4 !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL hold_stop_wait: phase %b want 0000", p4);
        end
        hold = 1'b0;
        tick();
        vectors++;
        if (p4 !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL hold_stop_first: phase %b want 0001", p4);
        end
    endtask

    task automatic test_back_to_back;
        run = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        run = 1'b1;
        vectors++;
        if (p4 !== 4'b0100 || busy4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_drain: phase %b busy %b want 0100 1", p4, busy4);
        end
        tick();
        vectors++;
        if (p4 !== 4'b1000 || done4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_last: phase %b done %b want 1000 1", p4, done4);
        end
        tick();
        vectors++;
        if (p4 !== 4'b0001 || busy4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_rerun: phase %b busy %b want 0001 1", p4, busy4);
        end
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        vectors++;
        if (p4 !== 4'b0000 || busy4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_boundary_stop: phase %b busy %b want 0000 0", p4, busy4);
        end
    endtask

    task automatic test_async_reset;
        run = 1'b1;
        do_reset();
        tick();
        tick();
        tick();
        tick();
        vectors++;
        if (p4 !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL areset_pre: phase %b want 0100", p4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({p4, idx4, done4, busy4} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL areset_now: got %b %b %b %b want all zero", p4, idx4, done4, busy4);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (p4 !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL areset_release: phase %b want 0000", p4);
        end
        tick();
        vectors++;
        if (p4 !== 4'b0001 || idx4 !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL areset_first: phase %b idx %0d want 0001 0", p4, idx4);
        end
    endtask

`ifdef PHASE_GEN_CYCLE_CNT_EN
    task automatic test_cycle_count;
        run = 1'b1;
        do_reset();
        tick();
        force dut4.cycle_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut4.cycle_cnt_q;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (cc4 !== 32'h0000_0000 || done4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL cycle_count_wrap: count %h done %b want 00000000 1", cc4, done4);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_run4();
        test_drain5();
        test_step();
        test_hold();
        test_hold_stop();
        test_back_to_back();
        test_async_reset();
`ifdef PHASE_GEN_CYCLE_CNT_EN
        test_cycle_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phase_gen.md
PHASE_GEN -- requirements
Module: phase_gen

Interface
REQ-001 Parameter NUM_PHASES, default 4, number of one-hot phase strobes per instruction cycle; legal range 2..16.
REQ-002 Parameter IDX_W, default $clog2(NUM_PHASES), width of PHASE_IDX.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 RUN  input  1  level; 1 = free-running sequencing requested.
REQ-006 STEP  input  1  one-cycle pulse; requests exactly one instruction cycle while stopped.
REQ-007 HOLD  input  1  level; stalls sequencing in place.
REQ-008 PHASE  output  NUM_PHASES  registered one-hot phase strobes, bit 0 first.
REQ-009 PHASE_IDX  output  IDX_W  registered index of the phase just issued.
REQ-010 CYCLE_DONE  output  1  registered pulse coincident with last-phase strobe.
REQ-011 BUSY  output  1  registered; 1 when state is RUN or DRAIN or SINGLE.

Function
REQ-012 Internal counter COUNT (IDX_W bits) selects the next phase; each advancing edge drives PHASE <= one-hot(COUNT), PHASE_IDX <= COUNT; COUNT <= COUNT+1, wrapping from NUM_PHASES-1 to 0.
REQ-013 Latency: first strobe PHASE[0] appears one CLK edge after the edge on which sequencing starts.
REQ-014 States: STOP, RUN, DRAIN, SINGLE; encoding two bits.
REQ-015 STOP: PHASE all zero, COUNT held at 0; RUN=1 -> RUN; else STEP=1 -> SINGLE; RUN has priority over STEP.
REQ-016 RUN: advance each edge; RUN=0 with COUNT!=0 -> DRAIN; RUN=0 with COUNT==0 -> STOP, no strobe.
REQ-017 DRAIN: advance each edge until the phase NUM_PHASES-1 strobe issues, then -> STOP; RUN=1 in DRAIN -> RUN without gap.
REQ-018 SINGLE: advance through all NUM_PHASES phases, then -> STOP; RUN and STEP ignored until STOP reached.
REQ-019 HOLD=1 in any non-STOP state: PHASE all zero, CYCLE_DONE 0, COUNT and state frozen; release resumes with the frozen COUNT phase, no phase skipped or repeated.
REQ-020 HOLD=1 in STOP: STEP ignored; RUN transition taken but first strobe waits for HOLD=0.
REQ-021 CYCLE_DONE = 1 exactly on edges issuing PHASE[NUM_PHASES-1].
REQ-022 Never more than one PHASE bit asserted; no strobe is ever partially wide or repeated.

Reset
REQ-023 RESET_N=0 asynchronously forces state STOP, COUNT 0, PHASE 0, PHASE_IDX 0, CYCLE_DONE 0, BUSY 0 (and CYCLE_COUNT 0 when present).
REQ-024 Reset mid-cycle abandons the instruction cycle; first strobe after release is PHASE[0].
REQ-025 Removal of reset is synchronous to CLK; no strobe on the release edge.

Configuration
REQ-026 Macro PHASE_GEN_CYCLE_CNT_EN defined: extra output CYCLE_COUNT (32 bits) increments on every CYCLE_DONE edge, wraps 0xFFFFFFFF -> 0, frozen by HOLD.
REQ-027 Macro undefined: CYCLE_COUNT port and counter absent; all other behaviour identical.

Structure
REQ-028 Shared package phase_gen_pkg holds the state enum (STOP, RUN, DRAIN, SINGLE) and the NUM_PHASES range constants.
REQ-029 One sub-module onehot_dec (IDX_W in, NUM_PHASES out, combinational) converts COUNT to one-hot; registered in phase_gen.
REQ-030 NUM_PHASES=4 with RUN tied 1, HOLD 0 reproduces the existing four-phase fetch/decode/execute/writeback sequencing.

Verification
REQ-031 NUM_PHASES=4, RUN=1 from reset release -> PHASE 0001,0010,0100,1000 repeating; CYCLE_DONE on every 4th edge.
REQ-032 NUM_PHASES=5, RUN dropped after PHASE[1] -> strobes 2,3,4 issue, CYCLE_DONE once, then STOP, PHASE 0, BUSY 0.
REQ-033 NUM_PHASES=4, STOP, STEP pulse -> exactly 4 strobes 0..3 then STOP; second STEP during SINGLE ignored.
REQ-034 RUN=1, HOLD high 3 edges after PHASE[2] -> 3 edges of PHASE 0, then PHASE[3], PHASE[0].
REQ-035 RESET_N low between clock edges during PHASE[2] -> outputs 0 immediately; after release with RUN=1, first strobe PHASE[0].
REQ-036 With PHASE_GEN_CYCLE_CNT_EN, CYCLE_COUNT preloaded 0xFFFFFFFF via force, one cycle run -> CYCLE_COUNT 0.
